// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Multiplexed common-anode 7-segment scan controller. One of CH packed nibble
//   sources is selected and latched as a whole frame at each frame boundary.
//   The latched frame is then scanned digit by digit with decimal points,
//   leading-zero suppression and 16-level PWM brightness.
//
//   Timing hierarchy: prescaler (SLOT_DIV/16 clocks) -> PWM phase (16 steps)
//   -> digit index (DIGITS slots) -> frame.
//
// Parameters
//   DIGITS    number of scanned digits (>= 2)
//   CH        number of selectable nibble sources (1..8, src_sel is 3 bits)
//   SLOT_DIV  clk_in cycles per digit slot (multiple of 16, >= 16)
//
// Ports
//   clk_in      in   system clock
//   rst_n       in   asynchronous active-low reset
//   data_in     in   CH*DIGITS nibbles; source c digit d at [(c*DIGITS+d)*4 +: 4]
//   src_sel     in   source index; values >= CH blank the frame
//   digit_en    in   per-digit enable (0 = digit always dark)
//   dp_in       in   per-digit decimal point (1 = lit)
//   lz_en       in   1 = suppress leading zeros
//   bright      in   PWM duty, digit on for (bright+1)/16 of its slot
//   seg_cs      out  digit select, active low, one-cold or all ones
//   seg_db      out  {a,b,c,d,e,f,g,dp}, active low
//   frame_tick  out  one-cycle pulse when a new frame has been latched
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int DIGITS   = 8,
   parameter int CH       = 3,
   parameter int SLOT_DIV = 1024
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic [CH*DIGITS*4-1:0]   data_in,
   input  logic [2:0]               src_sel,
   input  logic [DIGITS-1:0]        digit_en,
   input  logic [DIGITS-1:0]        dp_in,
   input  logic                     lz_en,
   input  logic [3:0]               bright,
   output logic [DIGITS-1:0]        seg_cs,
   output logic [7:0]               seg_db,
   output logic                     frame_tick
);

   localparam int PD = SLOT_DIV / 16;
   localparam int PW = (PD > 1) ? $clog2(PD) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int NW = DIGITS * 4;

   localparam logic [PW-1:0] PRESC_LAST = PW'(PD - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   // Hex digit to {a..g}, active low.
   function automatic logic [6:0] font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0:    f = 7'b0000001;
         4'h1:    f = 7'b1001111;
         4'h2:    f = 7'b0010010;
         4'h3:    f = 7'b0000110;
         4'h4:    f = 7'b1001100;
         4'h5:    f = 7'b0100100;
         4'h6:    f = 7'b0100000;
         4'h7:    f = 7'b0001111;
         4'h8:    f = 7'b0000000;
         4'h9:    f = 7'b0000100;
         4'hA:    f = 7'b0001000;
         4'hB:    f = 7'b1100000;
         4'hC:    f = 7'b0110001;
         4'hD:    f = 7'b1000010;
         4'hE:    f = 7'b0110000;
         4'hF:    f = 7'b0111000;
         default: f = 7'b1111111;
      endcase
      return f;
   endfunction

   // Scan counters
   logic [PW-1:0]     presc_q, presc_d;
   logic [3:0]        phase_q, phase_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [3:0]        bright_q, bright_d;

   // Frame shadow registers
   logic              sh_valid_q, sh_valid_d;
   logic [NW-1:0]     sh_nib_q, sh_nib_d;
   logic [DIGITS-1:0] sh_en_q, sh_en_d;
   logic [DIGITS-1:0] sh_dp_q, sh_dp_d;
   logic              sh_lz_q, sh_lz_d;

   // Output registers
   logic [DIGITS-1:0] seg_cs_q, seg_cs_d;
   logic [7:0]        seg_db_q, seg_db_d;
   logic              frame_tick_q, frame_tick_d;

   logic              slot_start_s;
   logic              frame_start_s;
   logic [NW-1:0]     sel_nib_s;
   logic              sel_valid_s;
   logic [DIGITS-1:0] supp_s;
   logic [3:0]        cur_nib_s;
   logic              lit_s;

   // Counters sit at zero right after reset, so the first slot after release
   // is automatically a frame boundary.
   assign slot_start_s  = (presc_q == {PW{1'b0}}) && (phase_q == 4'd0);
   assign frame_start_s = slot_start_s && (idx_q == {IW{1'b0}});

   // Prescaler, PWM phase and digit index advance.
   always_comb begin
      presc_d = presc_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = {PW{1'b0}};
         phase_d = phase_q + 4'd1;
         if (phase_q == 4'd15) begin
            if (idx_q == IDX_LAST) begin
               idx_d = {IW{1'b0}};
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end else begin
            idx_d = idx_q;
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Source multiplexer; an out-of-range select leaves sel_valid_s low.
   always_comb begin
      sel_nib_s   = {NW{1'b0}};
      sel_valid_s = 1'b0;
      for (int c = 0; c < CH; c++) begin
         sel_nib_s   = sel_nib_s | ({NW{src_sel == 3'(c)}} & data_in[c*NW +: NW]);
         sel_valid_s = sel_valid_s | (src_sel == 3'(c));
      end
   end

   // Frame latch at the boundary, brightness latch at every slot start.
   always_comb begin
      sh_valid_d   = sh_valid_q;
      sh_nib_d     = sh_nib_q;
      sh_en_d      = sh_en_q;
      sh_dp_d      = sh_dp_q;
      sh_lz_d      = sh_lz_q;
      bright_d     = bright_q;
      frame_tick_d = frame_start_s;
      if (frame_start_s) begin
         sh_valid_d = sel_valid_s;
         sh_nib_d   = sel_nib_s;
         sh_en_d    = digit_en;
         sh_dp_d    = dp_in;
         sh_lz_d    = lz_en;
      end else begin
         sh_valid_d = sh_valid_q;
      end
      if (slot_start_s) begin
         bright_d = bright;
      end else begin
         bright_d = bright_q;
      end
   end

   // Leading-zero suppression: a digit is blanked while it and every higher
   // digit read as zero; a disabled digit reads as zero. Digit 0 always shows.
   always_comb begin
      logic run;
      supp_s = {DIGITS{1'b0}};
      run    = sh_lz_q;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         run       = run & ((sh_nib_q[k*4 +: 4] == 4'd0) | ~sh_en_q[k]);
         supp_s[k] = run;
      end
   end

   assign cur_nib_s = sh_nib_q[{idx_q, 2'b00} +: 4];

   // The first clock of every slot is forced dark so the previous pattern
   // never ghosts onto the newly selected digit.
   assign lit_s = !slot_start_s && sh_valid_q && sh_en_q[idx_q] &&
                  !supp_s[idx_q] && (phase_q <= bright_q);

   // Select and pattern are computed together so they always refer to one digit.
   always_comb begin
      seg_cs_d = {DIGITS{1'b1}};
      seg_db_d = 8'hFF;
      if (lit_s) begin
         seg_cs_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
         seg_db_d = {font(cur_nib_s), ~sh_dp_q[idx_q]};
      end else begin
         seg_cs_d = {DIGITS{1'b1}};
         seg_db_d = 8'hFF;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= {PW{1'b0}};
         phase_q      <= 4'd0;
         idx_q        <= {IW{1'b0}};
         bright_q     <= 4'd0;
         sh_valid_q   <= 1'b0;
         sh_nib_q     <= {NW{1'b0}};
         sh_en_q      <= {DIGITS{1'b0}};
         sh_dp_q      <= {DIGITS{1'b0}};
         sh_lz_q      <= 1'b0;
         seg_cs_q     <= {DIGITS{1'b1}};
         seg_db_q     <= 8'hFF;
         frame_tick_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         bright_q     <= bright_d;
         sh_valid_q   <= sh_valid_d;
         sh_nib_q     <= sh_nib_d;
         sh_en_q      <= sh_en_d;
         sh_dp_q      <= sh_dp_d;
         sh_lz_q      <= sh_lz_d;
         seg_cs_q     <= seg_cs_d;
         seg_db_q     <= seg_db_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg_cs     = seg_cs_q;
   assign seg_db     = seg_db_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Scoreboard bench for seg_scan_ctrl (DIGITS=8, CH=3, SLOT_DIV=32).
//   The stimulus side programs one frame at a time, right before the frame
//   boundary, and pushes one entry per digit that should light. The monitor
//   pops an entry each time seg_cs leaves the all-ones state and checks the
//   select, the pattern and how many clocks the digit stays on.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int DIGITS   = 8;
   localparam int CH       = 3;
   localparam int SLOT_DIV = 32;

   logic                   clk_in = 1'b0;
   logic                   rst_n  = 1'b0;
   logic [CH*DIGITS*4-1:0] data_in  = '0;
   logic [2:0]             src_sel  = 3'd0;
   logic [DIGITS-1:0]      digit_en = '0;
   logic [DIGITS-1:0]      dp_in    = '0;
   logic                   lz_en    = 1'b0;
   logic [3:0]             bright   = 4'd0;
   logic [DIGITS-1:0]      seg_cs;
   logic [7:0]             seg_db;
   logic                   frame_tick;

   seg_scan_ctrl #(.DIGITS(DIGITS), .CH(CH), .SLOT_DIV(SLOT_DIV)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .src_sel   (src_sel),
      .digit_en  (digit_en),
      .dp_in     (dp_in),
      .lz_en     (lz_en),
      .bright    (bright),
      .seg_cs    (seg_cs),
      .seg_db    (seg_db),
      .frame_tick(frame_tick)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] cs;
      logic [7:0] db;
      int         len;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   tick_cnt = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference font {a..g}, active low, straight from the segment table.
   function automatic logic [6:0] ref_font(input logic [3:0] n);
      logic [6:0] tbl [16];
      tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      return tbl[n];
   endfunction

   // Drive one frame's inputs and queue the digits expected to light (mask is hand-derived).
   task automatic apply(input logic [2:0] src, input logic [31:0] w, input logic [7:0] en,
                        input logic [7:0] dp, input logic lz, input logic [3:0] br,
                        input logic [7:0] mask);
      exp_t e;
      src_sel = src;
      if (src < 3'd3) data_in[int'(src)*32 +: 32] = w;
      digit_en = en;
      dp_in    = dp;
      lz_en    = lz;
      bright   = br;
      for (int d = 0; d < 8; d++) begin
         if (mask[d]) begin
            e.cs  = ~(8'h01 << d);
            e.db  = {ref_font(w[d*4 +: 4]), ~dp[d]};
            e.len = 2 * int'(br) + 1;
            sb_q.push_back(e);
         end
      end
   endtask

   // Wait (bounded) for the frame tick; returns on the negedge where it is seen.
   task automatic wait_tick(input string name);
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!frame_tick && n < 400);
      total++;
      if (!frame_tick) begin
         bad++;
         $display("FAIL %s: frame_tick not seen within 400 clk", name);
      end
   endtask

   // Monitor: one scoreboard entry per lit run of seg_cs.
   initial begin
      exp_t cur;
      bit   in_run  = 1'b0;
      int   run_len = 0;
      forever begin
         @(negedge clk_in);
         if (!rst_n) begin
            in_run = 1'b0;
         end else begin
            if (frame_tick) tick_cnt++;
            if (in_run && seg_cs == cur.cs) begin
               run_len++;
            end else begin
               if (in_run && cur.len >= 0) check("lit_len", run_len, cur.len);
               in_run = 1'b0;
               if (seg_cs != 8'hFF) begin
                  if (sb_q.size() == 0) begin
                     check("unexpected_lit", {24'd0, seg_cs}, 32'hFF);
                     cur.cs = seg_cs;
                     cur.len = -1;
                  end else begin
                     cur = sb_q.pop_front();
                     check("seg_cs", {24'd0, seg_cs}, {24'd0, cur.cs});
                     check("seg_db", {24'd0, seg_db}, {24'd0, cur.db});
                  end
                  in_run  = 1'b1;
                  run_len = 1;
               end
            end
         end
      end
   end

   // Stimulus: each frame is programmed on the negedge right before its boundary.
   initial begin
      // Frame 0: basic scan, set up while in reset.
      apply(3'd1, 32'h1234_5678, 8'hFF, 8'h00, 1'b0, 4'd15, 8'hFF);
      repeat (3) @(negedge clk_in);
      check("rst_cs", {24'd0, seg_cs}, 32'hFF);
      check("rst_db", {24'd0, seg_db}, 32'hFF);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk_in);
      check("rel_tick", {31'd0, frame_tick}, 32'd1);
      check("rel_dead_cs", {24'd0, seg_cs}, 32'hFF);
      @(negedge clk_in);
      check("rel_dig0_cs", {24'd0, seg_cs}, 32'hFE);
      check("rel_dig0_db", {24'd0, seg_db}, 32'h01);
      repeat (254) @(negedge clk_in);

      // Frame 1/2: leading-zero suppression on and off.
      apply(3'd1, 32'h0000_0105, 8'hFF, 8'h00, 1'b1, 4'd15, 8'h07);
      wait_tick("tick_f1");
      repeat (255) @(negedge clk_in);
      apply(3'd1, 32'h0000_0105, 8'hFF, 8'h00, 1'b0, 4'd15, 8'hFF);
      wait_tick("tick_f2");
      repeat (255) @(negedge clk_in);

      // Frame 3: bright=3, data changed mid-frame (during digit 3) must not tear.
      apply(3'd2, 32'h89AB_CDEF, 8'hFF, 8'h00, 1'b0, 4'd3, 8'hFF);
      wait_tick("tick_f3");
      repeat (100) @(negedge clk_in);
      data_in[64 +: 32] = 32'h3210_FEDC;
      repeat (155) @(negedge clk_in);

      // Frame 4: new data becomes visible, bright=0.
      apply(3'd2, 32'h3210_FEDC, 8'hFF, 8'h00, 1'b0, 4'd0, 8'hFF);
      wait_tick("tick_f4");
      repeat (255) @(negedge clk_in);

      // Frame 5: invalid source, dark frame but tick still pulses.
      apply(3'd5, 32'h0, 8'hFF, 8'h00, 1'b0, 4'd15, 8'h00);
      wait_tick("tick_f5");
      repeat (255) @(negedge clk_in);

      // Frame 6: source 0, decimal point on digit 2, digit 3 disabled.
      apply(3'd0, 32'hDEAD_BEEF, 8'hF7, 8'h04, 1'b0, 4'd15, 8'hF7);
      wait_tick("tick_f6");
      repeat (255) @(negedge clk_in);

      // Frame 7: disabled digit counts as zero for suppression; only digit 0 shows.
      apply(3'd0, 32'h0000_7000, 8'hF7, 8'h04, 1'b1, 4'd15, 8'h01);
      wait_tick("tick_f7");
      repeat (255) @(negedge clk_in);

      // Frame 8: interrupted by reset while digit 1 is lit.
      apply(3'd1, 32'h1234_5678, 8'hFF, 8'h00, 1'b0, 4'd15, 8'hFF);
      wait_tick("tick_f8");
      repeat (40) @(negedge clk_in);
      check("mid_cs", {24'd0, seg_cs}, 32'hFD);
      check("mid_db", {24'd0, seg_db}, 32'h1F);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cs", {24'd0, seg_cs}, 32'hFF);
      check("async_rst_db", {24'd0, seg_db}, 32'hFF);
      check("async_rst_tick", {31'd0, frame_tick}, 32'd0);
      sb_q.delete();

      // Frame 9: fresh latch after release, scanning restarts at digit 0.
      apply(3'd2, 32'h0000_0042, 8'hFF, 8'h00, 1'b1, 4'd15, 8'h03);
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
      check("rel2_tick", {31'd0, frame_tick}, 32'd1);
      check("rel2_dead_cs", {24'd0, seg_cs}, 32'hFF);
      @(negedge clk_in);
      check("rel2_dig0_cs", {24'd0, seg_cs}, 32'hFE);
      check("rel2_dig0_db", {24'd0, seg_db}, 32'h25);
      repeat (254) @(negedge clk_in);

      // Frame 10: dark; closes out frame 9.
      apply(3'd7, 32'h0, 8'hFF, 8'h00, 1'b0, 4'd15, 8'h00);
      wait_tick("tick_f10");
      repeat (3) @(negedge clk_in);
      check("tick_count", tick_cnt, 11);
      check("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
